// File: rtl/alu_core_pkg.sv
// Shared constants for the URCPU ALU arithmetic slice.
// Contents:
//   ALU_DEFAULT_WIDTH - default operand/result width.
//   OP_*              - 5-bit opcodes from the CPU-wide ALU opcode map.
package alu_core_pkg;

    localparam int unsigned ALU_DEFAULT_WIDTH = 20;

    localparam logic [4:0] OP_AND = 5'd1;
    localparam logic [4:0] OP_ADD = 5'd8;
    localparam logic [4:0] OP_SUB = 5'd9;
    localparam logic [4:0] OP_CMP = 5'd12;

endpackage

// File: rtl/add_carry_unit.sv
// Combinational adder with optional operand inversion, shared by ADD and SUB.
// Ports:
//   a, b     - operands (WIDTH bits)
//   cin      - carry in (caller supplies inverted borrow for SUB)
//   invert_b - when 1, b is one's-complemented before the add
//   sum      - a + (b or ~b) + cin, modulo 2^WIDTH
//   cout     - carry out of bit WIDTH-1 (for SUB: 1 means no borrow)
module add_carry_unit #(
    parameter int unsigned WIDTH = 20
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             invert_b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    always_comb begin
        b_eff    = invert_b ? ~b : b;
        full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        sum      = full_sum[WIDTH-1:0];
        cout     = full_sum[WIDTH];
    end

endmodule

// File: rtl/alu_arith_core.sv
// Registered ALU slice for the URCPU execute stage: ADD, AND, CMP with flags.
// Optional SUB (op=9) is enabled by defining the macro ALU_CORE_SUB_EN.
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   en, op        - operation enable and 5-bit opcode, sampled on clk
//   a, b          - operands (WIDTH bits)
//   carry_in      - carry into ADD / borrow into SUB
//   res           - registered result
//   carry_out     - unsigned carry (ADD) or borrow (SUB)
//   overflow_out  - signed overflow toward negative
//   underflow_out - signed overflow toward positive
//   zero_out      - result zero (CMP: a == b)
//   sign_out      - result MSB (CMP: a < b unsigned)
//   valid_out     - one-cycle pulse after an accepted operation
module alu_arith_core
    import alu_core_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] res,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             underflow_out,
    output logic             zero_out,
    output logic             sign_out,
    output logic             valid_out
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             zero_q, zero_d;
    logic             sign_q, sign_d;
    logic             valid_q, valid_d;

    logic             invert_b;
    logic             adder_cin;
    logic [WIDTH-1:0] adder_sum;
    logic             adder_cout;

    // SUB is a + ~b + ~carry_in, so the incoming borrow is inverted as well.
`ifdef ALU_CORE_SUB_EN
    assign invert_b = (op == OP_SUB);
`else
    assign invert_b = 1'b0;
`endif
    assign adder_cin = invert_b ? ~carry_in : carry_in;

    add_carry_unit #(
        .WIDTH(WIDTH)
    ) u_add_carry_unit (
        .a        (a),
        .b        (b),
        .cin      (adder_cin),
        .invert_b (invert_b),
        .sum      (adder_sum),
        .cout     (adder_cout)
    );

    always_comb begin
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        valid_d = 1'b0;
        if (en) begin
            case (op)
                OP_ADD: begin
                    res_d   = adder_sum;
                    carry_d = adder_cout;
                    ovf_d   = ~a[MSB] & ~b[MSB] & adder_sum[MSB];
                    unf_d   = a[MSB] & b[MSB] & ~adder_sum[MSB];
                    zero_d  = (adder_sum == '0);
                    sign_d  = adder_sum[MSB];
                    valid_d = 1'b1;
                end
`ifdef ALU_CORE_SUB_EN
                OP_SUB: begin
                    res_d   = adder_sum;
                    carry_d = ~adder_cout;  // no carry out means a borrow occurred
                    ovf_d   = ~a[MSB] & b[MSB] & adder_sum[MSB];
                    unf_d   = a[MSB] & ~b[MSB] & ~adder_sum[MSB];
                    zero_d  = (adder_sum == '0);
                    sign_d  = adder_sum[MSB];
                    valid_d = 1'b1;
                end
`endif
                OP_AND: begin
                    res_d   = a & b;
                    zero_d  = ((a & b) == '0);
                    sign_d  = a[MSB] & b[MSB];
                    valid_d = 1'b1;
                end
                OP_CMP: begin
                    zero_d  = (a == b);
                    sign_d  = (a < b);
                    valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
            valid_q <= valid_d;
        end
    end

    assign res           = res_q;
    assign carry_out     = carry_q;
    assign overflow_out  = ovf_q;
    assign underflow_out = unf_q;
    assign zero_out      = zero_q;
    assign sign_out      = sign_q;
    assign valid_out     = valid_q;

endmodule

// File: tb/tb_alu_arith_core.sv
// Directed bench for alu_arith_core. Each step drives one operation, waits one
// edge and compares {res, carry, overflow, underflow, zero, sign, valid}.
module tb_alu_arith_core;

    localparam int unsigned WIDTH = 20;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic [WIDTH-1:0] res;
    logic             carry_out;
    logic             overflow_out;
    logic             underflow_out;
    logic             zero_out;
    logic             sign_out;
    logic             valid_out;

    int n_checks;
    int n_fail;

    alu_arith_core #(
        .WIDTH(WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .op            (op),
        .a             (a),
        .b             (b),
        .carry_in      (carry_in),
        .res           (res),
        .carry_out     (carry_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out),
        .zero_out      (zero_out),
        .sign_out      (sign_out),
        .valid_out     (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare current outputs against expected fields.
    task automatic check(input string tag, input logic [WIDTH-1:0] e_res, input logic e_c,
                         input logic e_o, input logic e_u, input logic e_z, input logic e_s,
                         input logic e_v);
        logic [WIDTH+5:0] obs;
        logic [WIDTH+5:0] exp;
        obs = {res, carry_out, overflow_out, underflow_out, zero_out, sign_out, valid_out};
        exp = {e_res, e_c, e_o, e_u, e_z, e_s, e_v};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed res=%05h c=%b o=%b u=%b z=%b s=%b v=%b expected res=%05h c=%b o=%b u=%b z=%b s=%b v=%b",
                   tag, obs[WIDTH+5:6], obs[5], obs[4], obs[3], obs[2], obs[1], obs[0],
                   exp[WIDTH+5:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one operation, then sample 1 time unit after the capturing edge.
    task automatic drive(input logic e, input logic [4:0] o, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb, input logic ci);
        en       = e;
        op       = o;
        a        = va;
        b        = vb;
        carry_in = ci;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        op       = 5'd8;
        a        = 20'h00001;
        b        = 20'h00001;
        carry_in = 1'b1;

        // Reset held with ops presented: everything stays 0.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", 20'h00000, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // ADD signed overflow
        drive(1, 5'd8, 20'h7FFFF, 20'h00001, 0);
        check("add_ovf", 20'h80000, 0, 1, 0, 0, 1, 1);
        drive(0, 5'd8, 20'h00001, 20'h00001, 0);
        check("add_ovf_valid_drop", 20'h80000, 0, 1, 0, 0, 1, 0);

        // ADD wrap
        drive(1, 5'd8, 20'h80000, 20'h80000, 0);
        check("add_wrap_unf", 20'h00000, 1, 0, 1, 1, 0, 1);
        drive(1, 5'd8, 20'hFFFFF, 20'h00000, 1);
        check("add_wrap_cin", 20'h00000, 1, 0, 0, 1, 0, 1);

        // AND: carry/overflow/underflow hold from the last ADD
        drive(1, 5'd1, 20'hF0F0F, 20'h0FF00, 1);
        check("and_basic", 20'h00F00, 1, 0, 0, 0, 0, 1);
        drive(1, 5'd1, 20'h80000, 20'hFFFFF, 0);
        check("and_sign", 20'h80000, 1, 0, 0, 0, 1, 1);

        // CMP: res and arithmetic flags hold
        drive(1, 5'd12, 20'h00005, 20'h00007, 0);
        check("cmp_lt", 20'h80000, 1, 0, 0, 0, 1, 1);
        drive(1, 5'd12, 20'h00007, 20'h00007, 0);
        check("cmp_eq", 20'h80000, 1, 0, 0, 1, 0, 1);
        drive(1, 5'd12, 20'h80000, 20'h00001, 0);
        check("cmp_unsigned", 20'h80000, 1, 0, 0, 0, 0, 1);

        // Hold cases
        drive(0, 5'd8, 20'h12345, 20'h11111, 0);
        check("hold_en0", 20'h80000, 1, 0, 0, 0, 0, 0);
        drive(1, 5'd3, 20'h12345, 20'h11111, 0);
        check("hold_op3", 20'h80000, 1, 0, 0, 0, 0, 0);

        drive(1, 5'd9, 20'h00000, 20'h00001, 0);
`ifdef ALU_CORE_SUB_EN
        check("sub_borrow", 20'hFFFFF, 1, 0, 0, 0, 1, 1);
`else
        check("hold_op9", 20'h80000, 1, 0, 0, 0, 0, 0);
`endif

        // Result, then asynchronous reset mid-cycle
        drive(1, 5'd8, 20'h00001, 20'h00002, 0);
        check("add_small", 20'h00003, 0, 0, 0, 0, 0, 1);
        en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 20'h00000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset release operates normally
        drive(1, 5'd8, 20'h12345, 20'h11111, 1);
        check("add_after_reset", 20'h23457, 0, 0, 0, 0, 0, 1);
        drive(1, 5'd8, 20'hFFFFF, 20'h00001, 0);
        check("add_b2b_carry", 20'h00000, 1, 0, 0, 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arith_core.md
Name: alu_arith_core

Overview:
- Registered 20-bit ALU slice covering the ADD, AND and CMP operations, with status flags, for the URCPU execute stage.
- Operands and opcode are sampled on a clock edge while enabled. The result and flags are registered and feed the register file and status register.
- Opcode encodings match the CPU-wide ALU opcode map.

Parameters:
- WIDTH, 20, operand/result width in bits; the sign bit is WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  operation enable; sampled on the rising clk edge.
- op  in  5  opcode: 1=AND, 8=ADD, 12=CMP (9=SUB only with the optional feature).
- a  in  WIDTH  operand 0.
- b  in  WIDTH  operand 1.
- carry_in  in  1  carry into ADD (and borrow into SUB).
- res  out  WIDTH  registered result.
- carry_out  out  1  unsigned carry out of bit WIDTH-1.
- overflow_out  out  1  signed overflow toward negative.
- underflow_out  out  1  signed overflow toward positive.
- zero_out  out  1  result-zero flag (CMP: equal).
- sign_out  out  1  result MSB (CMP: less-than).
- valid_out  out  1  one-cycle pulse the cycle after an accepted op.

Behaviour:
- Reset: while rst_n=0, all outputs are 0, asynchronously. The first edge after rst_n rises behaves normally.
- Latency: en=1 with a legal op at edge N updates the outputs, visible after edge N, with valid_out=1 for exactly that cycle.
- en=0 or an illegal op: all outputs hold their values and valid_out=0 at the next edge.
- Flags are always computed from the new result, never from the previously registered res.
- ADD: {carry_out,res} = a + b + carry_in, a (WIDTH+1)-bit sum, wrap-around modulo 2^WIDTH.
  - overflow_out = ~a[MSB] & ~b[MSB] & res[MSB].
  - underflow_out = a[MSB] & b[MSB] & ~res[MSB].
  - zero_out = (res==0); sign_out = res[MSB].
- AND: res = a & b; zero_out and sign_out from the new res. carry_out, overflow_out and underflow_out hold.
- CMP: unsigned comparison. zero_out = (a==b); sign_out = (a<b). res, carry_out, overflow_out and underflow_out hold.
- Back-to-back ops every cycle are supported; there is no stall or backpressure.
- Reset asserted mid-stream clears the outputs immediately; in-flight operands are discarded.

Optional Feature:
- Macro ALU_CORE_SUB_EN.
- Defined: op=9 is legal. SUB computes res = a - b - carry_in (mod 2^WIDTH).
  - carry_out = 1 when a borrow occurred, i.e. a < b + carry_in unsigned.
  - overflow_out = ~a[MSB] & b[MSB] & res[MSB].
  - underflow_out = a[MSB] & ~b[MSB] & ~res[MSB].
  - zero_out and sign_out from the new res.
- Undefined: op=9 is illegal and holds all outputs like any other unknown opcode.

Decomposition:
- Package alu_core_pkg: opcode localparams (OP_AND=5'd1, OP_ADD=5'd8, OP_SUB=5'd9, OP_CMP=5'd12) and the default width constant 20.
- One combinational sub-module, add_carry_unit (WIDTH parameter): inputs a, b, cin, invert_b; outputs sum, cout.
  - Shared by ADD, and by SUB through invert_b with the carry sense inverted.
  - The CMP less-than and equal signals derive from its subtract path or from direct comparators, at implementer's choice.
- Register bank and opcode decode live in alu_arith_core.

Test Plan:
- Reset: hold rst_n=0 and drive en=1 with ops -> all outputs 0. Assert rst_n=0 asynchronously mid-clock after a result -> outputs 0 immediately.
- ADD signed overflow: a=0x7FFFF, b=0x00001, cin=0 -> res=0x80000, overflow=1, underflow=0, carry=0, sign=1, zero=0, valid pulse 1 cycle later.
- ADD wrap: a=0x80000, b=0x80000, cin=0 -> res=0x00000, carry=1, underflow=1, zero=1, sign=0. Then a=0xFFFFF, b=0x00000, cin=1 -> res=0, carry=1, underflow=0.
- AND: a=0xF0F0F, b=0x0FF00 -> res=0x00F00, zero=0, sign=0, carry/overflow/underflow unchanged from the prior ADD. Then a=0x80000, b=0xFFFFF -> sign=1.
- CMP: a=5, b=7 -> sign=1, zero=0; a=7, b=7 -> zero=1, sign=0; a=0x80000, b=1 -> sign=0 (unsigned). res unchanged in all cases.
- Hold and illegal op: en=0, or op=3 (and op=9 without ALU_CORE_SUB_EN) -> outputs unchanged, valid=0. With ALU_CORE_SUB_EN: a=0, b=1, cin=0 -> res=0xFFFFF, carry=1, sign=1.
